// File: rtl/tiny_riscv_mem_arbiter_if.sv
// Bundles the fetch, load/store and external memory signals of the memory arbiter.
// The slave modport is the arbiter's view; master is the surrounding core/memory view.
interface tiny_riscv_mem_arbiter_if #(
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 32
);
  logic              if_req;
  logic [AW-1:0]     if_addr;
  logic [DW-1:0]     if_rdata;
  logic              if_ack;

  logic              ls_req;
  logic              ls_we;
  logic [AW-1:0]     ls_addr;
  logic [DW-1:0]     ls_wdata;
  logic [DW/8-1:0]   ls_wstrb;
  logic [DW-1:0]     ls_rdata;
  logic              ls_ack;

  logic              mem_req;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [DW/8-1:0]   mem_wstrb;
  logic [DW-1:0]     mem_rdata;
  logic              mem_ready;

  logic              busy;
  logic              owner;

  modport slave (
    input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_wstrb, mem_rdata, mem_ready,
    output if_rdata, if_ack, ls_rdata, ls_ack, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
           busy, owner
  );

  modport master (
    output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, ls_wstrb, mem_rdata, mem_ready,
    input  if_rdata, if_ack, ls_rdata, ls_ack, mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
           busy, owner
  );
endinterface

// File: rtl/tiny_riscv_mem_arbiter.sv
// Shares one external memory port between instruction fetch (IF) and load/store (LS).
// One transaction at a time; LS wins ties unless IF has waited through STARVE_MAX LS grants.
module tiny_riscv_mem_arbiter #(
  parameter int unsigned AW         = 16,
  parameter int unsigned DW         = 32,
  parameter int unsigned STARVE_MAX = 3
) (
  input logic                     clk,
  input logic                     rst_n,
  tiny_riscv_mem_arbiter_if.slave bus
);
  localparam int unsigned SW = DW / 8;
  localparam int unsigned CW = $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] StarveLimit = CW'(STARVE_MAX);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] starve_q, starve_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [SW-1:0] mem_wstrb_q, mem_wstrb_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] ls_rdata_q, ls_rdata_d;
  logic          if_ack_q, if_ack_d;
  logic          ls_ack_q, ls_ack_d;
  logic          busy_q, busy_d;
  logic          owner_q, owner_d;
  logic          grant_ls;

  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wstrb_d = mem_wstrb_q;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    if_ack_d    = 1'b0;
    ls_ack_d    = 1'b0;
    busy_d      = busy_q;
    owner_d     = owner_q;
    // Starvation guard: a waiting fetch overrides LS priority once the limit is reached.
    grant_ls    = bus.ls_req && !(bus.if_req && (starve_q == StarveLimit));

    unique case (state_q)
      StIdle: begin
        if (bus.ls_req || bus.if_req) begin
          state_d   = StBusy;
          busy_d    = 1'b1;
          mem_req_d = 1'b1;
          if (grant_ls) begin
            owner_d     = 1'b1;
            mem_we_d    = bus.ls_we;
            mem_addr_d  = bus.ls_addr;
            mem_wdata_d = bus.ls_wdata;
            mem_wstrb_d = bus.ls_wstrb;
            starve_d    = bus.if_req ? starve_q + CW'(1) : '0;
          end else begin
            owner_d     = 1'b0;
            mem_we_d    = 1'b0;
            mem_addr_d  = bus.if_addr;
            mem_wdata_d = '0;
            mem_wstrb_d = '0;
            starve_d    = '0;
          end
        end
      end
      StBusy: begin
        if (bus.mem_ready) begin
          state_d   = StDone;
          mem_req_d = 1'b0;
          if (owner_q) begin
            ls_ack_d = 1'b1;
            if (!mem_we_q) ls_rdata_d = bus.mem_rdata;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = bus.mem_rdata;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        busy_d  = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      starve_q    <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wstrb_q <= '0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      ls_ack_q    <= 1'b0;
      busy_q      <= 1'b0;
      owner_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wstrb_q <= mem_wstrb_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
      if_ack_q    <= if_ack_d;
      ls_ack_q    <= ls_ack_d;
      busy_q      <= busy_d;
      owner_q     <= owner_d;
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wstrb = mem_wstrb_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.ls_rdata  = ls_rdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.ls_ack    = ls_ack_q;
  assign bus.busy      = busy_q;
  assign bus.owner     = owner_q;
endmodule

// File: tb/tb_tiny_riscv_mem_arbiter.sv
// Self-checking bench for tiny_riscv_mem_arbiter: directed vector table, hand-written corner
// sequences and a randomized phase checked against a transaction-level arbitration model.
module tb_tiny_riscv_mem_arbiter;
  localparam int unsigned AW   = 16;
  localparam int unsigned DW   = 32;
  localparam int unsigned SMAX = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  tiny_riscv_mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  tiny_riscv_mem_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(SMAX)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory responder: wait count per transaction, data is a function of the address.
  int          fixed_wait  = -1;
  int          cur_wait    = 0;
  int          rcnt        = 0;
  bit          ovr_en      = 1'b0;
  logic [31:0] ovr_val     = '0;
  bit          force_ready = 1'b0;

  function automatic logic [31:0] mem_fn(input logic [15:0] a);
    return ovr_en ? ovr_val : {a ^ 16'h5A5A, ~a};
  endfunction

  initial begin
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_req) begin
        if (rcnt == 0) cur_wait = (fixed_wait >= 0) ? fixed_wait : int'($urandom_range(0, 3));
        bus.mem_ready = (rcnt == cur_wait);
        bus.mem_rdata = bus.mem_ready ? mem_fn(bus.mem_addr) : $urandom;
        rcnt++;
      end else begin
        rcnt          = 0;
        bus.mem_ready = force_ready;
        bus.mem_rdata = $urandom;
      end
    end
  end

  typedef struct {
    bit          is_ls;
    bit          we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    int          wt;
    logic [31:0] mdata;
    logic [31:0] exp_if;
    logic [31:0] exp_ls;
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input vec_t v, input int idx);
    int mreq_cycles = 0;
    int acks = 0;
    int wrong = 0;
    @(negedge clk);
    fixed_wait = v.wt;
    ovr_en     = 1'b1;
    ovr_val    = v.mdata;
    if (v.is_ls) begin
      bus.ls_req   = 1'b1;
      bus.ls_we    = v.we;
      bus.ls_addr  = v.addr;
      bus.ls_wdata = v.wdata;
      bus.ls_wstrb = v.wstrb;
    end else begin
      bus.if_req  = 1'b1;
      bus.if_addr = v.addr;
    end
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (bus.mem_req) begin
        mreq_cycles++;
        check($sformatf("vec%0d mem_addr", idx), bus.mem_addr, v.addr);
        check($sformatf("vec%0d mem_we", idx), bus.mem_we, v.is_ls & v.we);
        check($sformatf("vec%0d mem_wdata", idx), bus.mem_wdata, v.is_ls ? v.wdata : 32'h0);
        check($sformatf("vec%0d mem_wstrb", idx), bus.mem_wstrb, v.is_ls ? v.wstrb : 4'h0);
        check($sformatf("vec%0d owner", idx), bus.owner, v.is_ls);
      end
      if (v.is_ls ? bus.ls_ack : bus.if_ack) begin
        acks++;
        check($sformatf("vec%0d if_rdata", idx), bus.if_rdata, v.exp_if);
        check($sformatf("vec%0d ls_rdata", idx), bus.ls_rdata, v.exp_ls);
        bus.if_req = 1'b0;
        bus.ls_req = 1'b0;
      end
      if (v.is_ls ? bus.if_ack : bus.ls_ack) wrong++;
    end
    check($sformatf("vec%0d mem_req cycles", idx), mreq_cycles, v.wt + 1);
    check($sformatf("vec%0d ack count", idx), acks, 1);
    check($sformatf("vec%0d wrong-port acks", idx), wrong, 0);
    check($sformatf("vec%0d busy after", idx), bus.busy, 1'b0);
    ovr_en = 1'b0;
  endtask

  initial begin
    bit          pend_if, pend_ls, prev_mreq, prev_idle, mreq, done_now, exp_ls_win;
    bit          g_owner, g_we;
    logic [15:0] g_addr;
    logic [31:0] exp_if_rd, exp_ls_rd, snap_if, snap_ls;
    int          starve, bcyc, n, ack_cyc, g_cyc, cyc, acks, mcyc;
    bit          owners[8];
    logic [15:0] gaddr[2];

    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.ls_req = 1'b0; bus.ls_we = 1'b0; bus.ls_addr = '0; bus.ls_wdata = '0; bus.ls_wstrb = '0;

    vecs[0] = '{1'b0, 1'b0, 16'h0040, 32'h0, 4'h0, 2, 32'h00A00093, 32'h00A00093, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 16'h0300, 32'h0, 4'h0, 0, 32'h12345678, 32'h00A00093, 32'h12345678};
    vecs[2] = '{1'b1, 1'b1, 16'h0200, 32'hDEADBEEF, 4'b0011, 1, 32'h55555555,
                32'h00A00093, 32'h12345678};
    vecs[3] = '{1'b0, 1'b0, 16'hFFFC, 32'h0, 4'h0, 0, 32'hCAFEF00D, 32'hCAFEF00D, 32'h12345678};
    vecs[4] = '{1'b1, 1'b0, 16'h0001, 32'h0, 4'h0, 3, 32'h0BADC0DE, 32'hCAFEF00D, 32'h0BADC0DE};
    vecs[5] = '{1'b1, 1'b1, 16'hABCD, 32'h0, 4'hF, 0, 32'h77777777, 32'hCAFEF00D, 32'h0BADC0DE};

    // Reset state
    repeat (2) @(negedge clk);
    check("reset busy", bus.busy, 1'b0);
    check("reset mem_req", bus.mem_req, 1'b0);
    check("reset owner", bus.owner, 1'b0);
    check("reset acks", {bus.if_ack, bus.ls_ack}, 2'b00);
    check("reset rdata", {bus.if_rdata, bus.ls_rdata}, 64'h0);
    check("reset mem bus", {bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb}, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Simultaneous IF and LS requests: LS first, IF in the IDLE cycle after ls_ack
    @(negedge clk);
    fixed_wait = 0;
    bus.if_req = 1'b1; bus.if_addr = 16'h0044;
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 16'h0100;
    n = 0; prev_mreq = 1'b0; ack_cyc = -100; g_cyc = -1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.mem_req && !prev_mreq) begin
        if (n < 2) begin
          owners[n] = bus.owner;
          gaddr[n]  = bus.mem_addr;
        end
        if (n == 1) g_cyc = c;
        n++;
      end
      if (bus.ls_ack) begin
        ack_cyc = c;
        bus.ls_req = 1'b0;
        check("simul ls_rdata", bus.ls_rdata, mem_fn(16'h0100));
      end
      if (bus.if_ack) begin
        bus.if_req = 1'b0;
        check("simul if_rdata", bus.if_rdata, mem_fn(16'h0044));
      end
      prev_mreq = bus.mem_req;
    end
    check("simul grants", n, 2);
    check("simul first owner", owners[0], 1'b1);
    check("simul first addr", gaddr[0], 16'h0100);
    check("simul second owner", owners[1], 1'b0);
    check("simul second addr", gaddr[1], 16'h0044);
    check("simul IF grant gap", g_cyc - ack_cyc, 2);

    // Starvation guard: both held, expect LS,LS,LS,IF repeating
    @(negedge clk);
    fixed_wait = -1;
    bus.if_req = 1'b1; bus.if_addr = 16'h0080;
    bus.ls_req = 1'b1; bus.ls_we = 1'b0; bus.ls_addr = 16'h0300;
    n = 0; prev_mreq = 1'b0;
    for (int c = 0; c < 70; c++) begin
      @(negedge clk);
      if (bus.mem_req && !prev_mreq) begin
        if (n < 8) owners[n] = bus.owner;
        n++;
      end
      if ((bus.if_ack || bus.ls_ack) && n >= 8) begin
        bus.if_req = 1'b0;
        bus.ls_req = 1'b0;
      end
      prev_mreq = bus.mem_req;
    end
    check("starve grants", n, 8);
    for (int i = 0; i < 8; i++)
      check($sformatf("starve grant%0d owner", i), owners[i], (i % 4 == 3) ? 1'b0 : 1'b1);

    // mem_ready pulses in IDLE and DONE are ignored
    @(negedge clk);
    snap_if = bus.if_rdata; snap_ls = bus.ls_rdata;
    force_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("idle ready busy", bus.busy, 1'b0);
      check("idle ready acks", {bus.if_ack, bus.ls_ack}, 2'b00);
    end
    check("idle ready if_rdata", bus.if_rdata, snap_if);
    check("idle ready ls_rdata", bus.ls_rdata, snap_ls);
    fixed_wait = 0;
    bus.if_req = 1'b1; bus.if_addr = 16'h0010;
    acks = 0; mcyc = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (bus.mem_req) mcyc++;
      if (bus.if_ack || bus.ls_ack) begin
        acks++;
        bus.if_req = 1'b0;
      end
    end
    check("done ready acks", acks, 1);
    check("done ready mem_req cycles", mcyc, 1);
    check("done ready if_rdata", bus.if_rdata, mem_fn(16'h0010));
    check("done ready ls_rdata", bus.ls_rdata, snap_ls);
    force_ready = 1'b0;

    // Asynchronous reset in the middle of a stalled store
    @(negedge clk);
    fixed_wait = 1000;
    bus.ls_req = 1'b1; bus.ls_we = 1'b1; bus.ls_addr = 16'h0777;
    bus.ls_wdata = 32'hA5A5A5A5; bus.ls_wstrb = 4'hC;
    repeat (2) @(negedge clk);
    check("pre-reset busy", {bus.busy, bus.mem_req, bus.owner, bus.mem_we}, 4'hF);
    #2 rst_n = 1'b0;
    bus.ls_req = 1'b0;
    #1;
    check("async reset mem_req", bus.mem_req, 1'b0);
    check("async reset mem bus", {bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb}, 0);
    check("async reset rdata", {bus.if_rdata, bus.ls_rdata}, 64'h0);
    check("async reset acks", {bus.if_ack, bus.ls_ack}, 2'b00);
    check("async reset busy/owner", {bus.busy, bus.owner}, 2'b00);
    @(negedge clk);
    rst_n = 1'b1;
    fixed_wait = -1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("post-reset idle", {bus.busy, bus.mem_req}, 2'b00);
    end

    // Randomized traffic against a transaction-level model
    pend_if = 1'b0; pend_ls = 1'b0; prev_mreq = 1'b0; prev_idle = 1'b1;
    starve = 0; bcyc = 0; exp_if_rd = '0; exp_ls_rd = '0;
    g_owner = 1'b0; g_we = 1'b0; g_addr = '0;
    for (cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      mreq     = bus.mem_req;
      done_now = prev_mreq && !mreq;
      if (prev_idle) check("rnd grant taken", mreq, pend_if || pend_ls);
      if (mreq && !prev_mreq) begin
        exp_ls_win = pend_ls && !(pend_if && starve == SMAX);
        check("rnd owner", bus.owner, exp_ls_win);
        if (exp_ls_win) begin
          check("rnd ls fields", {bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb},
                {bus.ls_we, bus.ls_addr, bus.ls_wdata, bus.ls_wstrb});
          starve = pend_if ? starve + 1 : 0;
          g_addr = bus.ls_addr; g_we = bus.ls_we;
        end else begin
          check("rnd if fields", {bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_wstrb},
                {1'b0, bus.if_addr, 32'h0, 4'h0});
          starve = 0;
          g_addr = bus.if_addr; g_we = 1'b0;
        end
        g_owner = exp_ls_win;
        bcyc = 1;
      end else if (mreq) begin
        bcyc++;
        check("rnd addr stable", bus.mem_addr, g_addr);
      end
      check("rnd busy", bus.busy, mreq || done_now);
      check("rnd acks", {bus.if_ack, bus.ls_ack},
            done_now ? (g_owner ? 2'b01 : 2'b10) : 2'b00);
      if (done_now) begin
        check("rnd latency", bcyc, cur_wait + 1);
        if (!g_owner) exp_if_rd = mem_fn(g_addr);
        else if (!g_we) exp_ls_rd = mem_fn(g_addr);
        check("rnd if_rdata", bus.if_rdata, exp_if_rd);
        check("rnd ls_rdata", bus.ls_rdata, exp_ls_rd);
        if (!g_owner) begin
          if ($urandom_range(0, 1) == 0) bus.if_req = 1'b0;
          else bus.if_addr = 16'($urandom);
        end else begin
          if ($urandom_range(0, 1) == 0) bus.ls_req = 1'b0;
          else begin
            bus.ls_we = 1'($urandom); bus.ls_addr = 16'($urandom);
            bus.ls_wdata = $urandom; bus.ls_wstrb = 4'($urandom);
          end
        end
      end
      if (!bus.if_req && $urandom_range(0, 2) == 0) begin
        bus.if_req = 1'b1; bus.if_addr = 16'($urandom);
      end
      if (!bus.ls_req && $urandom_range(0, 2) == 0) begin
        bus.ls_req = 1'b1; bus.ls_we = 1'($urandom); bus.ls_addr = 16'($urandom);
        bus.ls_wdata = $urandom; bus.ls_wstrb = 4'($urandom);
      end
      pend_if   = bus.if_req;
      pend_ls   = bus.ls_req;
      prev_mreq = mreq;
      prev_idle = !(mreq || done_now);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/tiny_riscv_mem_arbiter.md
# tiny_riscv_mem_arbiter

Shares the single external memory port of `tt_um_tiny_riscv` between the core's instruction-fetch unit (IF) and its load/store unit (LS). It runs one transaction at a time through an IDLE/BUSY/DONE state machine and tolerates any memory latency via `mem_ready`. LS has fixed priority over IF, and a bounded starvation guard stops a stream of loads/stores from locking out fetch. The block sits between the core pipeline and the uio-pin memory interface logic.

## Interface
Parameters:
- `AW`, 16, address width
- `DW`, 32, data width
- `STARVE_MAX`, 3, maximum consecutive LS grants while IF is waiting (≥1)

Ports:
- `clk`  in  1  clock; all logic on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `if_req`  in  1  fetch request; held until `if_ack`
- `if_addr`  in  AW  fetch address
- `if_rdata`  out  DW  fetched word
- `if_ack`  out  1  one-cycle fetch completion
- `ls_req`  in  1  load/store request; held until `ls_ack`
- `ls_we`  in  1  1 = store, 0 = load
- `ls_addr`  in  AW  load/store address
- `ls_wdata`  in  DW  store data
- `ls_wstrb`  in  DW/8  store byte enables
- `ls_rdata`  out  DW  load data
- `ls_ack`  out  1  one-cycle load/store completion
- `mem_req`  out  1  memory transaction active
- `mem_we`  out  1  write strobe
- `mem_addr`  out  AW  memory address
- `mem_wdata`  out  DW  write data
- `mem_wstrb`  out  DW/8  byte enables
- `mem_rdata`  in  DW  read data, valid when `mem_ready`=1
- `mem_ready`  in  1  memory completes the current transaction
- `busy`  out  1  state ≠ IDLE
- `owner`  out  1  port of the current or last grant: 0 = IF, 1 = LS

## Operation
- **IDLE**
  - Arbitrate only in this state. Grant LS if `ls_req`=1, except grant IF when `if_req`=1 and `starve_cnt`==STARVE_MAX.
  - Grant IF if only `if_req`=1.
  - No request: stay in IDLE.
  - On a grant: latch address, we, wdata and wstrb into the `mem_*` registers, set `owner`, go to BUSY.
  - IF grants always drive `mem_we`=0, `mem_wdata`=0, `mem_wstrb`=0.
- **starve_cnt** (width `$clog2(STARVE_MAX+1)`)
  - LS grant while `if_req`=1: increment.
  - LS grant while `if_req`=0: clear to 0.
  - IF grant: clear to 0.
  - Never exceeds STARVE_MAX.
- **BUSY**
  - `mem_req`=1. All `mem_*` outputs stay stable.
  - `mem_ready`=0: stay in BUSY with no timeout.
  - `mem_ready`=1: capture `mem_rdata` into `if_rdata` for an IF read or `ls_rdata` for an LS load, then go to DONE.
  - An LS store does not change `ls_rdata`.
- **DONE**
  - Assert `ack` to the owner for exactly this cycle, then go to IDLE.
  - `mem_req`=0.
  - Requests are not sampled in DONE. A requester that keeps `req` high after its ack is treated as a new request in the following IDLE cycle.
- `mem_ready` outside BUSY is ignored.
- Request inputs that change while the port is not yet granted are sampled only in IDLE. Requester fields must be stable from `req` rise until the grant.
- **Reset (asynchronous, any state)**
  - Return to IDLE; clear `starve_cnt`.
  - All outputs go to 0: `mem_*`, both `rdata`, both `ack`, `busy`, `owner`.
  - Any in-flight memory transaction is abandoned with no ack.

## Timing
- `mem_req`, `mem_*`, `*_ack`, `*_rdata`, `busy` and `owner` are all registered; there are no combinational paths from inputs to outputs.
- Grant to `mem_req`: `req` sampled high in IDLE at edge N, so `mem_req`=1 from N.
- With `mem_ready` high in the first BUSY cycle (edge N+1), `ack` is high for cycle N+1..N+2.
- Fastest transaction is 3 cycles, request to IDLE again. Back-to-back throughput is one transaction per 3 + (memory wait) cycles.
- Each cycle `mem_ready` stays low adds exactly one BUSY cycle.
- `rdata` is valid in the `ack` cycle and holds until the next read to the same port.

## Test plan
- **Reset:** assert `rst_n`=0 mid-BUSY with `mem_ready`=0 → all outputs 0 immediately (asynchronous). After release with no requests → `busy`=0 and `mem_req`=0 indefinitely.
- **Single fetch with wait states:** `if_req`=1, `if_addr`=0x0040; memory holds `mem_ready`=0 for 2 cycles, then 1 with `mem_rdata`=0x00A00093.
  - Expect `mem_addr`=0x0040, `mem_we`=0, `mem_req` high for 3 cycles.
  - Then `if_ack` for one cycle with `if_rdata`=0x00A00093; `ls_ack` never asserted.
- **Simultaneous requests:** `if_req` and `ls_req` (load 0x0100) rise in the same cycle → LS served first (`owner`=1), IF granted in the IDLE cycle after `ls_ack`.
- **Starvation guard:** STARVE_MAX=3; `ls_req` held high continuously and `if_req` high → grant sequence LS, LS, LS, IF, LS, LS, LS, IF…
- **Store:** `ls_we`=1, `ls_addr`=0x0200, `ls_wdata`=0xDEADBEEF, `ls_wstrb`=0b0011; `ls_rdata` preloaded 0x12345678.
  - Expect `mem_we`=1 and `mem_wstrb`=0011 in BUSY.
  - Expect `ls_ack` once, with `ls_rdata` still 0x12345678.
- **Ignored mem_ready:** pulse `mem_ready`=1 while in IDLE and in DONE → no state change, no `ack`, `rdata` unchanged.
